// File: rtl/peak_window_sched_pkg.sv
// Shared types and constants for the peak-hold window scheduler.
package peak_window_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_SEND
  } state_t;

  localparam int unsigned DEFAULT_WIN = 150000;
  localparam int unsigned MIN_WIN     = 2;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/peak_acc.sv
// Single-channel unsigned running maximum; nxt already includes the current sample.
module peak_acc #(
  parameter int unsigned DW = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          tick,
  input  logic          din_vld,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] nxt
);

  logic [DW-1:0] acc;

  always_comb begin
    nxt = (din_vld && (din > acc)) ? din : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr || tick) begin
      acc <= '0;
    end else begin
      acc <= nxt;
    end
  end

endmodule

// File: rtl/peak_window_sched.sv
// Windowed multi-channel peak-hold: per-window snapshot streamed out one channel per beat.
module peak_window_sched
  import peak_window_sched_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DW          = 48,
  parameter int unsigned CW          = 32,
  parameter int unsigned DEFAULT_WIN = peak_window_sched_pkg::DEFAULT_WIN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [CW-1:0]               cfg_win_len,
  input  logic                        cfg_load,
  input  logic [NCH*DW-1:0]           din,
  input  logic                        din_vld,
  output logic [DW-1:0]               m_data,
  output logic [ch_width(NCH)-1:0]    m_ch,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        win_tick,
  output logic                        ovf
);

  localparam int unsigned CHW = ch_width(NCH);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   win_len_r;
  logic [CW-1:0]   act_len;
  logic [CW-1:0]   cfg_len;
  logic [CHW-1:0]  ch;
  logic [DW-1:0]   snap [NCH];
  logic [DW-1:0]   nxt  [NCH];
  logic            tick;
  logic            hs;
  logic            last_hs;
  logic            load_snap;
  logic            acc_clr;

  always_comb begin
    cfg_len   = (cfg_win_len < CW'(MIN_WIN)) ? CW'(MIN_WIN) : cfg_win_len;
    tick      = (state != S_IDLE) && (cnt == act_len - CW'(1));
    hs        = (state == S_SEND) && m_ready;
    last_hs   = hs && (ch == CHW'(NCH - 1));
    load_snap = tick && ((state == S_ACC) || last_hs);
    acc_clr   = !enable || (state == S_IDLE);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    peak_acc #(.DW(DW)) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (acc_clr),
      .tick    (tick),
      .din_vld (din_vld),
      .din     (din[g*DW +: DW]),
      .nxt     (nxt[g])
    );
  end

  // win_len_r holds the programmed length; act_len only follows it in idle or at a window boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_len_r <= CW'(DEFAULT_WIN);
      act_len   <= CW'(DEFAULT_WIN);
    end else begin
      if (cfg_load) begin
        win_len_r <= cfg_len;
      end
      if ((state == S_IDLE) || tick) begin
        act_len <= cfg_load ? cfg_len : win_len_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !enable || (state == S_IDLE) || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch   <= '0;
      ovf  <= 1'b0;
      snap <= '{default: '0};
    end else if (!enable) begin
      ch  <= '0;
      ovf <= 1'b0;
    end else begin
      if (load_snap) begin
        snap <= nxt;
        ch   <= '0;
      end else if (hs) begin
        ch <= (ch == CHW'(NCH - 1)) ? '0 : ch + CHW'(1);
      end
      if ((state == S_SEND) && tick && !last_hs) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_ACC;
        S_ACC:  if (tick) state_nxt = S_SEND;
        S_SEND: if (!tick && last_hs) state_nxt = S_ACC;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs decode only registered state, so they carry no combinational path from inputs.
  always_comb begin
    m_valid  = 1'b0;
    m_ch     = '0;
    m_data   = '0;
    m_last   = 1'b0;
    win_tick = tick;
    if (state == S_SEND) begin
      m_valid = 1'b1;
      m_ch    = ch;
      m_data  = snap[ch];
      m_last  = (ch == CHW'(NCH - 1));
    end
  end

endmodule

// File: tb/tb_peak_window_sched.sv
// Directed self-checking bench for peak_window_sched.
module tb_peak_window_sched;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [31:0]   cfg_win_len;
  logic          cfg_load;
  logic [191:0]  din;
  logic          din_vld;
  logic [47:0]   m_data;
  logic [1:0]    m_ch;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          win_tick;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  peak_window_sched #(
    .NCH(4),
    .DW(48),
    .CW(32),
    .DEFAULT_WIN(12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .cfg_win_len (cfg_win_len),
    .cfg_load    (cfg_load),
    .din         (din),
    .din_vld     (din_vld),
    .m_data      (m_data),
    .m_ch        (m_ch),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .win_tick    (win_tick),
    .ovf         (ovf)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [47:0] a, input logic [47:0] b,
                       input logic [47:0] c, input logic [47:0] d, input logic v);
    din     = {d, c, b, a};
    din_vld = v;
  endtask

  task automatic do_reset;
    rst_n       = 1'b0;
    enable      = 1'b0;
    cfg_load    = 1'b0;
    cfg_win_len = '0;
    m_ready     = 1'b1;
    drive(48'd0, 48'd0, 48'd0, 48'd0, 1'b0);
    step;
    step;
    rst_n = 1'b1;
  endtask

  // Leaves the bench in cycle 0 of the first window (counter == 0).
  task automatic start(input int unsigned len);
    cfg_win_len = len;
    cfg_load    = 1'b1;
    step;
    cfg_load = 1'b0;
    enable   = 1'b1;
    step;
  endtask

  task automatic test_reset;
    do_reset;
    for (int j = 0; j < 3; j++) begin
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid j=%0d got %b exp 0", j, m_valid); end
      checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last j=%0d got %b exp 0", j, m_last); end
      checks++; if (m_data !== 48'd0) begin errors++; $display("FAIL reset_m_data j=%0d got %h exp 0", j, m_data); end
      checks++; if (m_ch !== 2'd0) begin errors++; $display("FAIL reset_m_ch j=%0d got %0d exp 0", j, m_ch); end
      checks++; if (win_tick !== 1'b0) begin errors++; $display("FAIL reset_win_tick j=%0d got %b exp 0", j, win_tick); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf j=%0d got %b exp 0", j, ovf); end
      step;
    end
  endtask

  task automatic test_ramp;
    logic [47:0] exp_d;
    logic [1:0]  b;
    logic        exp_v, exp_t;
    do_reset;
    m_ready = 1'b1;
    start(8);
    for (int k = 0; k < 20; k++) begin
      drive(48'(k + 1), 48'd5, (k == 3) ? 48'hFFFF_FFFF_FFFF : 48'd0, 48'd0, 1'b1);
      exp_t = (k == 7) || (k == 15);
      exp_v = (k >= 8 && k <= 11) || (k >= 16);
      b = 2'(k % 4);
      case (b)
        2'd0:    exp_d = (k < 16) ? 48'd8 : 48'd16;
        2'd1:    exp_d = 48'd5;
        2'd2:    exp_d = (k < 16) ? 48'hFFFF_FFFF_FFFF : 48'd0;
        default: exp_d = 48'd0;
      endcase
      checks++; if (win_tick !== exp_t) begin errors++; $display("FAIL ramp_tick k=%0d got %b exp %b", k, win_tick, exp_t); end
      checks++; if (m_valid !== exp_v) begin errors++; $display("FAIL ramp_valid k=%0d got %b exp %b", k, m_valid, exp_v); end
      if (exp_v) begin
        checks++; if (m_ch !== b) begin errors++; $display("FAIL ramp_ch k=%0d got %0d exp %0d", k, m_ch, b); end
        checks++; if (m_data !== exp_d) begin errors++; $display("FAIL ramp_data k=%0d got %h exp %h", k, m_data, exp_d); end
        checks++; if (m_last !== (b == 2'd3)) begin errors++; $display("FAIL ramp_last k=%0d got %b exp %b", k, m_last, (b == 2'd3)); end
      end
      step;
    end
  endtask

  task automatic test_final_sample;
    do_reset;
    m_ready = 1'b1;
    start(8);
    for (int k = 0; k < 20; k++) begin
      if (k < 8) drive((k == 7) ? 48'd100 : 48'd0, 48'd0, 48'd0, 48'd0, 1'b1);
      else       drive(48'hDEAD_BEEF_0000, 48'hDEAD_BEEF_0000, 48'hDEAD_BEEF_0000, 48'hDEAD_BEEF_0000, 1'b0);
      if (k == 8) begin
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL final_valid got %b exp 1", m_valid); end
        checks++; if (m_data !== 48'd100) begin errors++; $display("FAIL final_sample got %0d exp 100", m_data); end
      end
      if (k >= 16) begin
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL vld_gate_valid k=%0d got %b exp 1", k, m_valid); end
        checks++; if (m_data !== 48'd0) begin errors++; $display("FAIL vld_gate_data k=%0d got %h exp 0", k, m_data); end
      end
      step;
    end
  endtask

  task automatic test_backpressure;
    logic [47:0] exp_d;
    int          b;
    do_reset;
    m_ready = 1'b0;
    start(64);
    for (int k = 0; k < 89; k++) begin
      drive((k == 5) ? 48'd777 : 48'd1, 48'd20, 48'd30, 48'd40, 1'b1);
      m_ready = (k >= 84);
      if (k == 63) begin
        checks++; if (win_tick !== 1'b1) begin errors++; $display("FAIL bp_tick got %b exp 1", win_tick); end
      end
      if (k >= 64 && k <= 83) begin
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid k=%0d got %b exp 1", k, m_valid); end
        checks++; if (m_ch !== 2'd0) begin errors++; $display("FAIL bp_hold_ch k=%0d got %0d exp 0", k, m_ch); end
        checks++; if (m_data !== 48'd777) begin errors++; $display("FAIL bp_hold_data k=%0d got %0d exp 777", k, m_data); end
      end
      if (k >= 84 && k <= 87) begin
        b = k - 84;
        exp_d = (b == 0) ? 48'd777 : 48'(10 * (b + 1));
        checks++; if (m_ch !== 2'(b)) begin errors++; $display("FAIL bp_beat_ch k=%0d got %0d exp %0d", k, m_ch, b); end
        checks++; if (m_data !== exp_d) begin errors++; $display("FAIL bp_beat_data k=%0d got %0d exp %0d", k, m_data, exp_d); end
        checks++; if (m_last !== (b == 3)) begin errors++; $display("FAIL bp_beat_last k=%0d got %b exp %b", k, m_last, (b == 3)); end
      end
      if (k == 88) begin
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %b exp 0", m_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf got %b exp 0", ovf); end
      end
      step;
    end
  endtask

  task automatic test_overflow;
    int b;
    do_reset;
    m_ready = 1'b0;
    start(4);
    for (int k = 0; k < 15; k++) begin
      if (k < 4) drive(48'd11, 48'd22, 48'd33, 48'd44, 1'b1);
      else       drive(48'd99, 48'd99, 48'd99, 48'd99, 1'b1);
      m_ready = (k >= 9);
      enable  = (k < 13);
      if (k == 7) begin
        checks++; if (win_tick !== 1'b1) begin errors++; $display("FAIL ovf_tick2 got %b exp 1", win_tick); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ovf); end
      end
      if (k == 8) begin
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
        checks++; if (m_data !== 48'd11) begin errors++; $display("FAIL ovf_snap_kept got %0d exp 11", m_data); end
      end
      if (k >= 9 && k <= 12) begin
        b = k - 9;
        checks++; if (m_ch !== 2'(b)) begin errors++; $display("FAIL ovf_beat_ch k=%0d got %0d exp %0d", k, m_ch, b); end
        checks++; if (m_data !== 48'(11 * (b + 1))) begin errors++; $display("FAIL ovf_beat_data k=%0d got %0d exp %0d", k, m_data, 11 * (b + 1)); end
      end
      if (k == 13) begin
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
      end
      if (k == 14) begin
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_idle_valid got %b exp 0", m_valid); end
      end
      step;
    end
  endtask

  task automatic test_boundary;
    logic exp_t;
    do_reset;
    m_ready = 1'b1;
    start(4);
    for (int k = 0; k < 17; k++) begin
      if (k < 4) drive(48'd1, 48'd2, 48'd3, 48'd4, 1'b1);
      else       drive(48'd10, 48'd20, 48'd30, 48'd40, 1'b1);
      cfg_win_len = 32'd1;
      cfg_load    = (k == 9);
      if (k == 7) begin
        checks++; if (win_tick !== 1'b1) begin errors++; $display("FAIL bnd_tick got %b exp 1", win_tick); end
        checks++; if (m_last !== 1'b1) begin errors++; $display("FAIL bnd_last got %b exp 1", m_last); end
        checks++; if (m_data !== 48'd4) begin errors++; $display("FAIL bnd_last_data got %0d exp 4", m_data); end
      end
      if (k == 8) begin
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bnd_valid got %b exp 1", m_valid); end
        checks++; if (m_ch !== 2'd0) begin errors++; $display("FAIL bnd_ch got %0d exp 0", m_ch); end
        checks++; if (m_data !== 48'd10) begin errors++; $display("FAIL bnd_data got %0d exp 10", m_data); end
      end
      if (k == 12) begin
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL bnd_ovf got %b exp 0", ovf); end
      end
      if (k >= 8) begin
        exp_t = (k == 11) || (k == 13) || (k == 15);
        checks++; if (win_tick !== exp_t) begin errors++; $display("FAIL bnd_period k=%0d got %b exp %b", k, win_tick, exp_t); end
      end
      step;
    end
    cfg_load = 1'b0;
  endtask

  task automatic test_reset_abort;
    do_reset;
    m_ready = 1'b1;
    start(8);
    drive(48'd5, 48'd6, 48'd7, 48'd8, 1'b1);
    for (int k = 0; k < 10; k++) step;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL abort_pre_valid got %b exp 1", m_valid); end
    rst_n = 1'b0;
    step;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL midrst_last got %b exp 0", m_last); end
    checks++; if (m_data !== 48'd0) begin errors++; $display("FAIL midrst_data got %h exp 0", m_data); end
    checks++; if (m_ch !== 2'd0) begin errors++; $display("FAIL midrst_ch got %0d exp 0", m_ch); end
    checks++; if (win_tick !== 1'b0) begin errors++; $display("FAIL midrst_tick got %b exp 0", win_tick); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL midrst_ovf got %b exp 0", ovf); end
    rst_n = 1'b1;
    step;
    for (int k = 0; k < 13; k++) begin
      checks++; if (win_tick !== (k == 11)) begin errors++; $display("FAIL default_len k=%0d got %b exp %b", k, win_tick, (k == 11)); end
      if (k == 12) begin
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL abort_send_valid got %b exp 1", m_valid); end
        enable = 1'b0;
      end
      step;
    end
    for (int j = 0; j < 3; j++) begin
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL abort_valid j=%0d got %b exp 0", j, m_valid); end
      step;
    end
    enable = 1'b1;
    step;
    for (int k = 0; k < 12; k++) begin
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reen_valid k=%0d got %b exp 0", k, m_valid); end
      checks++; if (win_tick !== (k == 11)) begin errors++; $display("FAIL reen_tick k=%0d got %b exp %b", k, win_tick, (k == 11)); end
      step;
    end
  endtask

  initial begin
    test_reset;
    test_ramp;
    test_final_sample;
    test_backpressure;
    test_overflow;
    test_boundary;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
